alu_share_arbiter: RTL and testbench
====================================

# alu_share_arbiter

Round-robin arbiter that time-shares one combinational `alu` instance between two requesters, such as the main execute path and a branch/address helper. Each requester has a valid/ready request channel and a one-entry registered response slot. The block drives the ALU's opsel/sub/unsigned/arith/op inputs from the granted request and captures the result, eq and slt one cycle later. A saturating conflict counter records arbitration stalls for performance debug.

## Interface
Parameters:
- `RR_EN`, default 1: 1 selects round-robin; 0 selects fixed priority, with requester 0 always winning.
- `CNT_W`, default 16: width of the conflict counter.

Ports:
- `i_clk` in 1: the block's single clock. All state updates on the rising edge.
- `i_rst` in 1: reset, synchronous and active-high.
- `i_req0_valid` in 1: requester 0 presents an operation.
- `o_req0_ready` out 1: requester 0's operation is accepted this cycle.
- `i_req0_opsel` in 3: ALU operation select, same encoding as `alu`.
- `i_req0_sub`, `i_req0_unsigned`, `i_req0_arith` in 1 each: ALU modifier bits.
- `i_req0_op1`, `i_req0_op2` in 32 each: ALU operands.
- `i_req1_*`: identical set for requester 1.
- `o_rsp0_valid` out 1: response slot 0 holds a result.
- `i_rsp0_ready` in 1: requester 0 consumes the response.
- `o_rsp0_result` out 32: ALU result. `o_rsp0_eq` out 1, `o_rsp0_slt` out 1: comparison flags.
- `o_rsp1_*`, `i_rsp1_ready`: identical set for requester 1.
- `o_alu_opsel` out 3, `o_alu_sub` out 1, `o_alu_unsigned` out 1, `o_alu_arith` out 1: drive the `alu` control inputs.
- `o_alu_op1`, `o_alu_op2` out 32 each: drive the `alu` operand inputs.
- `i_alu_result` in 32, `i_alu_eq` in 1, `i_alu_slt` in 1: returned from `alu`.
- `o_conflict_cnt` out CNT_W: saturating count of stalled-request cycles.

## Operation
- **Slot availability:** slot N is available when `!o_rspN_valid || i_rspN_ready`. This permits drain and refill in the same cycle.
- **Eligibility:** requester N is eligible when `i_reqN_valid` is high and slot N is available.
- **Grant:** at most one grant per cycle.
  - Only one requester eligible: it is granted.
  - Both eligible, RR_EN=1: grant the requester not served by the last grant. The `last` pointer updates only on a grant.
  - Both eligible, RR_EN=0: grant requester 0.
- **Ready:** `o_reqN_ready` equals grantN, and is combinational from the valids, slot states and pointer. Requesters must not make valid depend on ready.
- **ALU drive when granted:** the ALU outputs carry the granted request's fields combinationally.
- **ALU drive when idle:** all ALU outputs are driven to 0, giving opsel 000 (add 0+0).
- **Capture:** on a grant edge, slot N loads `i_alu_result`, `i_alu_eq` and `i_alu_slt`, and `o_rspN_valid` is set.
- **Drain:** on `o_rspN_valid && i_rspN_ready` without a new grant to N, valid clears.
- **Payload hold:** slot payload is stable while valid is high and not consumed.
- **Conflict counter:** increments on each cycle where some requester has `i_reqN_valid` high and `o_reqN_ready` low. This covers both lost arbitration and a full slot. It saturates at all-ones, holds there, and never wraps.
- **State elements:**
  - `last` pointer (1 bit)
  - two slot valids
  - two payload registers (34 bits each)
  - conflict counter

## Timing
- **Reset values:**
  - `o_rsp0_valid`, `o_rsp1_valid` = 0.
  - Response payloads = 0.
  - `o_conflict_cnt` = 0.
  - `last` = 1, so requester 0 wins the first tie.
  - Readies and ALU outputs follow combinationally from these values and are 0 while the inputs are idle.
- **Reset mid-operation:** a pending response is discarded. `i_rst` dominates a simultaneous grant or drain.
- **Latency:** acceptance at edge k gives `o_rspN_valid` high after edge k, i.e. one cycle.
- **Throughput:** one operation per cycle in total. Each requester sustains one operation per cycle if its response is drained every cycle.
- **Simultaneous events:**
  - Drain and new grant to the same slot in one cycle: valid stays 1 and the payload updates.
  - Grant to one requester and drain of the other slot: independent.
- **Full slot:** with `o_rspN_valid`=1 and `i_rspN_ready`=0, requester N is never granted. The other requester may still be granted, and the `last` pointer is unaffected by N.

## Test plan
- **Single op:** reset; req0 add op1=5, op2=7 with sub=0 for one cycle, rsp0_ready=1 → ready0=1 that cycle; next cycle rsp0_valid=1, result=12, eq=0, slt=0.
- **Tie round-robin:** req0 and req1 both valid continuously with rsp ready=1; req0 does sub 10-3, req1 does xor 0xF0^0x0F → grants alternate 0,1,0,1. Results are 7 and 0xFF. conflict_cnt increments by 1 per cycle.
- **Backpressure:** slot1 full and rsp1_ready=0; req1 and req0 both valid → ready1=0, req0 granted every cycle. The rsp1 payload is unchanged. When rsp1_ready=1, req1 is granted in the same cycle.
- **Drain and refill:** req0 valid every cycle with rsp0_ready=1; slt unsigned 1 vs 0xFFFFFFFF, then signed → rsp0_valid stays high; results are 1, then 0 on back-to-back cycles.
- **Counter saturation:** CNT_W=4; hold req1 blocked for 20 cycles → count reaches 15 and stays at 15.
- **Mid-op reset:** assert i_rst for one cycle while a grant is in flight → after the edge, rsp valids=0, count=0, and the next tie goes to requester 0.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// Two-requester arbiter time-sharing one external combinational ALU.
// Each requester owns a one-entry registered response slot; stalls feed a saturating counter.

module alu_share_slot (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_grant,
  input  logic        i_ready,
  input  logic [31:0] i_result,
  input  logic        i_eq,
  input  logic        i_slt,
  output logic        o_valid,
  output logic [31:0] o_result,
  output logic        o_eq,
  output logic        o_slt
);
  logic        r_valid;
  logic [33:0] r_pay;

  // A grant wins over a drain so the slot can empty and refill in one cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_valid <= 1'b0;
      r_pay   <= '0;
    end else if (i_grant) begin
      r_valid <= 1'b1;
      r_pay   <= {i_result, i_eq, i_slt};
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid  = r_valid;
  assign o_result = r_pay[33:2];
  assign o_eq     = r_pay[1];
  assign o_slt    = r_pay[0];
endmodule

module alu_share_arbiter #(
  parameter int RR_EN = 1,
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_req0_valid,
  output logic             o_req0_ready,
  input  logic [2:0]       i_req0_opsel,
  input  logic             i_req0_sub,
  input  logic             i_req0_unsigned,
  input  logic             i_req0_arith,
  input  logic [31:0]      i_req0_op1,
  input  logic [31:0]      i_req0_op2,
  input  logic             i_req1_valid,
  output logic             o_req1_ready,
  input  logic [2:0]       i_req1_opsel,
  input  logic             i_req1_sub,
  input  logic             i_req1_unsigned,
  input  logic             i_req1_arith,
  input  logic [31:0]      i_req1_op1,
  input  logic [31:0]      i_req1_op2,
  output logic             o_rsp0_valid,
  input  logic             i_rsp0_ready,
  output logic [31:0]      o_rsp0_result,
  output logic             o_rsp0_eq,
  output logic             o_rsp0_slt,
  output logic             o_rsp1_valid,
  input  logic             i_rsp1_ready,
  output logic [31:0]      o_rsp1_result,
  output logic             o_rsp1_eq,
  output logic             o_rsp1_slt,
  output logic [2:0]       o_alu_opsel,
  output logic             o_alu_sub,
  output logic             o_alu_unsigned,
  output logic             o_alu_arith,
  output logic [31:0]      o_alu_op1,
  output logic [31:0]      o_alu_op2,
  input  logic [31:0]      i_alu_result,
  input  logic             i_alu_eq,
  input  logic             i_alu_slt,
  output logic [CNT_W-1:0] o_conflict_cnt
);
  localparam int NUM_REQ = 2;

  typedef struct packed {
    logic [2:0]  opsel;
    logic        sub;
    logic        uns;
    logic        arith;
    logic [31:0] op1;
    logic [31:0] op2;
  } req_t;

  req_t [NUM_REQ-1:0]        w_req;
  req_t                      w_alu;
  logic [NUM_REQ-1:0]        w_vld;
  logic [NUM_REQ-1:0]        w_rsp_rdy;
  logic [NUM_REQ-1:0]        w_rsp_vld;
  logic [NUM_REQ-1:0]        w_avail;
  logic [NUM_REQ-1:0]        w_elig;
  logic [NUM_REQ-1:0]        w_grant;
  logic [NUM_REQ-1:0][31:0]  w_rsp_res;
  logic [NUM_REQ-1:0]        w_rsp_eq;
  logic [NUM_REQ-1:0]        w_rsp_slt;
  logic                      w_stall;
  logic                      r_last;
  logic [CNT_W-1:0]          r_cnt;

  assign w_req[0]  = '{i_req0_opsel, i_req0_sub, i_req0_unsigned, i_req0_arith,
                       i_req0_op1, i_req0_op2};
  assign w_req[1]  = '{i_req1_opsel, i_req1_sub, i_req1_unsigned, i_req1_arith,
                       i_req1_op1, i_req1_op2};
  assign w_vld     = {i_req1_valid, i_req0_valid};
  assign w_rsp_rdy = {i_rsp1_ready, i_rsp0_ready};
  assign w_avail   = ~w_rsp_vld | w_rsp_rdy;
  assign w_elig    = w_vld & w_avail;

  // On a tie, r_last names the previous winner; the other side goes next.
  always_comb begin
    w_grant = '0;
    case (w_elig)
      2'b01:   w_grant = 2'b01;
      2'b10:   w_grant = 2'b10;
      2'b11:   w_grant = (RR_EN != 0 && !r_last) ? 2'b10 : 2'b01;
      default: w_grant = '0;
    endcase
  end

  always_comb begin
    w_alu = '0;
    if (w_grant[1])      w_alu = w_req[1];
    else if (w_grant[0]) w_alu = w_req[0];
  end

  assign o_alu_opsel    = w_alu.opsel;
  assign o_alu_sub      = w_alu.sub;
  assign o_alu_unsigned = w_alu.uns;
  assign o_alu_arith    = w_alu.arith;
  assign o_alu_op1      = w_alu.op1;
  assign o_alu_op2      = w_alu.op2;

  assign o_req0_ready = w_grant[0];
  assign o_req1_ready = w_grant[1];
  assign w_stall      = |(w_vld & ~w_grant);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_last <= 1'b1;
      r_cnt  <= '0;
    end else begin
      if (|w_grant) r_last <= w_grant[1];
      if (w_stall && r_cnt != {CNT_W{1'b1}}) r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_conflict_cnt = r_cnt;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_slot
    alu_share_slot u_slot (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_grant  (w_grant[g]),
      .i_ready  (w_rsp_rdy[g]),
      .i_result (i_alu_result),
      .i_eq     (i_alu_eq),
      .i_slt    (i_alu_slt),
      .o_valid  (w_rsp_vld[g]),
      .o_result (w_rsp_res[g]),
      .o_eq     (w_rsp_eq[g]),
      .o_slt    (w_rsp_slt[g])
    );
  end

  assign o_rsp0_valid  = w_rsp_vld[0];
  assign o_rsp0_result = w_rsp_res[0];
  assign o_rsp0_eq     = w_rsp_eq[0];
  assign o_rsp0_slt    = w_rsp_slt[0];
  assign o_rsp1_valid  = w_rsp_vld[1];
  assign o_rsp1_result = w_rsp_res[1];
  assign o_rsp1_eq     = w_rsp_eq[1];
  assign o_rsp1_slt    = w_rsp_slt[1];
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter; a small behavioural ALU closes the loop.
module tb_alu_share_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        r0v, r0s, r0u, r0a, r1v, r1s, r1u, r1a;
  logic [2:0]  r0op, r1op;
  logic [31:0] r0a1, r0a2, r1a1, r1a2;
  logic        rdy0, rdy1, s0v, s1v, s0e, s1e, s0l, s1l, p0r, p1r;
  logic [31:0] s0r, s1r;
  logic [2:0]  aop;
  logic        asub, auns, aari;
  logic [31:0] aa, ab, ares;
  logic        aeq, aslt, cmp;
  logic [3:0]  cnt;
  logic [31:0] cnt32;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;
  assign cnt32 = {28'b0, cnt};

  alu_share_arbiter #(.RR_EN(1), .CNT_W(4)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req0_valid(r0v), .o_req0_ready(rdy0), .i_req0_opsel(r0op), .i_req0_sub(r0s),
    .i_req0_unsigned(r0u), .i_req0_arith(r0a), .i_req0_op1(r0a1), .i_req0_op2(r0a2),
    .i_req1_valid(r1v), .o_req1_ready(rdy1), .i_req1_opsel(r1op), .i_req1_sub(r1s),
    .i_req1_unsigned(r1u), .i_req1_arith(r1a), .i_req1_op1(r1a1), .i_req1_op2(r1a2),
    .o_rsp0_valid(s0v), .i_rsp0_ready(p0r), .o_rsp0_result(s0r), .o_rsp0_eq(s0e), .o_rsp0_slt(s0l),
    .o_rsp1_valid(s1v), .i_rsp1_ready(p1r), .o_rsp1_result(s1r), .o_rsp1_eq(s1e), .o_rsp1_slt(s1l),
    .o_alu_opsel(aop), .o_alu_sub(asub), .o_alu_unsigned(auns), .o_alu_arith(aari),
    .o_alu_op1(aa), .o_alu_op2(ab), .i_alu_result(ares), .i_alu_eq(aeq), .i_alu_slt(aslt),
    .o_conflict_cnt(cnt)
  );

  // Reference ALU: 000 add/sub, 001 sll, 010 slt, 011 sltu, 100 xor, 101 srl/sra, 110 or, 111 and.
  always_comb begin
    cmp = auns ? (aa < ab) : ($signed(aa) < $signed(ab));
    ares = '0;
    case (aop)
      3'b000: ares = asub ? aa - ab : aa + ab;
      3'b001: ares = aa << ab[4:0];
      3'b010: ares = {31'b0, cmp};
      3'b011: ares = {31'b0, aa < ab};
      3'b100: ares = aa ^ ab;
      3'b101: ares = aari ? 32'($signed(aa) >>> ab[4:0]) : aa >> ab[4:0];
      3'b110: ares = aa | ab;
      default: ares = aa & ab;
    endcase
    aeq  = (aa == ab);
    aslt = (asub || aop == 3'b010) ? cmp : 1'b0;
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    r0v = 0; r0op = 0; r0s = 0; r0u = 0; r0a = 0; r0a1 = 0; r0a2 = 0;
    r1v = 0; r1op = 0; r1s = 0; r1u = 0; r1a = 0; r1a1 = 0; r1a2 = 0;
    p0r = 1; p1r = 1;
    step(); step();
    rst = 1'b0;
    #1;
    chk1("rst_rsp0_valid", s0v, 1'b0);
    chk1("rst_rsp1_valid", s1v, 1'b0);
    chk32("rst_rsp0_result", s0r, 32'h0);
    chk32("rst_cnt", cnt32, 32'h0);
    chk1("rst_ready0", rdy0, 1'b0);
    chk32("rst_alu_op1", aa, 32'h0);

    // single op: 5 + 7
    r0v = 1; r0op = 3'b000; r0s = 0; r0a1 = 5; r0a2 = 7;
    #1;
    chk1("single_ready0", rdy0, 1'b1);
    chk32("single_alu_op1", aa, 32'd5);
    step();
    r0v = 0;
    #1;
    chk1("single_rsp0_valid", s0v, 1'b1);
    chk32("single_result", s0r, 32'd12);
    chk1("single_eq", s0e, 1'b0);
    chk1("single_slt", s0l, 1'b0);
    chk32("single_alu_idle", {29'b0, aop} | aa | ab, 32'h0);
    step();
    chk1("single_drained", s0v, 1'b0);
    chk32("single_cnt", cnt32, 32'h0);

    // tie round-robin: req0 10-3, req1 0xF0^0x0F
    do_reset();
    r0v = 1; r0op = 3'b000; r0s = 1; r0a1 = 10; r0a2 = 3;
    r1v = 1; r1op = 3'b100; r1s = 0; r1a1 = 32'hF0; r1a2 = 32'h0F;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk1("rr_ready0", rdy0, (i % 2) == 0);
      chk1("rr_ready1", rdy1, (i % 2) == 1);
      step();
      chk32("rr_cnt", cnt32, 32'(i + 1));
      if (i % 2 == 0) begin
        chk1("rr_rsp0_valid", s0v, 1'b1);
        chk32("rr_rsp0_result", s0r, 32'd7);
      end else begin
        chk1("rr_rsp1_valid", s1v, 1'b1);
        chk32("rr_rsp1_result", s1r, 32'hFF);
      end
    end
    r0v = 0; r1v = 0; r0s = 0;

    // backpressure: fill slot1 with 0x30|0x03, then hold it
    do_reset();
    p1r = 0;
    r1v = 1; r1op = 3'b110; r1a1 = 32'h30; r1a2 = 32'h03;
    step();
    chk32("bp_fill_result", s1r, 32'h33);
    r1op = 3'b111; r1a1 = 32'hFF; r1a2 = 32'h0F;
    r0v = 1; r0op = 3'b000; r0a1 = 1; r0a2 = 2;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk1("bp_ready1", rdy1, 1'b0);
      chk1("bp_ready0", rdy0, 1'b1);
      step();
      chk32("bp_rsp1_hold", s1r, 32'h33);
      chk32("bp_rsp0_result", s0r, 32'd3);
    end
    chk32("bp_cnt", cnt32, 32'd3);
    p1r = 1;
    #1;
    chk1("bp_release_ready1", rdy1, 1'b1);
    chk1("bp_release_ready0", rdy0, 1'b0);
    step();
    chk32("bp_new_rsp1", s1r, 32'h0F);
    chk1("bp_new_rsp1_valid", s1v, 1'b1);
    chk32("bp_cnt2", cnt32, 32'd4);
    r0v = 0; r1v = 0;

    // drain and refill: sltu 1 vs 0xFFFFFFFF, then signed slt
    do_reset();
    r0v = 1; r0op = 3'b010; r0u = 1; r0a1 = 1; r0a2 = 32'hFFFF_FFFF;
    step();
    r0u = 0;
    chk1("dr_valid_a", s0v, 1'b1);
    chk32("dr_result_a", s0r, 32'd1);
    #1;
    chk1("dr_ready0", rdy0, 1'b1);
    step();
    chk1("dr_valid_b", s0v, 1'b1);
    chk32("dr_result_b", s0r, 32'd0);
    r0v = 0;

    // saturation: block req1 behind a full slot
    do_reset();
    p1r = 0; r1v = 1; r1op = 3'b000; r1a1 = 1; r1a2 = 1;
    step();
    chk32("sat_start", cnt32, 32'd0);
    for (int i = 1; i <= 20; i++) begin
      step();
      if (i == 14) chk32("sat_14", cnt32, 32'd14);
      if (i == 15) chk32("sat_15", cnt32, 32'd15);
    end
    chk32("sat_hold", cnt32, 32'd15);

    // mid-op reset with a grant in flight
    r0v = 1; r0op = 3'b000; r0a1 = 2; r0a2 = 2; p1r = 1;
    rst = 1;
    step();
    rst = 0;
    #1;
    chk1("mr_rsp0_valid", s0v, 1'b0);
    chk1("mr_rsp1_valid", s1v, 1'b0);
    chk32("mr_cnt", cnt32, 32'd0);
    chk1("mr_tie_ready0", rdy0, 1'b1);
    chk1("mr_tie_ready1", rdy1, 1'b0);
    r0v = 0; r1v = 0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
